// File: rtl/bird_game_controller.sv
// Per-frame flappy-bird sequencer: bird position/velocity, flap input, gap collision, game FSM.
// Optional DEATH_FLASH_EN: palette-invert flashing while the bird is dying.
module bird_game_controller #(
  parameter int START_Y      = 240,
  parameter int GRAVITY      = 1,
  parameter int FLAP_IMPULSE = 8,
  parameter int MAX_FALL     = 8,
  parameter int Y_MIN        = 157,
  parameter int Y_MAX        = 324,
  parameter int FLOOR_Y      = 474,
  parameter int DYING_FRAMES = 60,
  parameter int FLASH_PERIOD = 8
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        frame_tick,
  input  logic        flap,
  input  logic        start,
  output logic [31:0] bird_y,
  output logic        inverted,
  output logic        playing,
  output logic        game_over,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic signed [6:0]  LP_GRAV     = 7'(GRAVITY);
  localparam logic signed [6:0]  LP_MAXF     = 7'(MAX_FALL);
  localparam logic signed [5:0]  LP_FLAP_VEL = 6'(-FLAP_IMPULSE);
  localparam logic signed [11:0] LP_YMIN     = 12'(Y_MIN);
  localparam logic signed [11:0] LP_YMAX     = 12'(Y_MAX);
  localparam logic signed [11:0] LP_FLOOR    = 12'(FLOOR_Y);
  localparam logic signed [11:0] LP_CEIL     = 12'sd6;
  localparam logic [9:0]         LP_START    = 10'(START_Y);
  localparam logic [5:0]         LP_DLAST    = 6'(DYING_FRAMES - 1);

  state_t             r_state, w_state_n;
  logic [9:0]         r_bird_y, w_bird_y_n;
  logic signed [5:0]  r_vel, w_vel_n;
  logic [15:0]        r_score, w_score_n;
  logic [5:0]         r_dcnt, w_dcnt_n;
  logic               r_flap_s1, r_flap_s2, r_flap_d, r_flap_pend;
  logic               w_edge;
  logic signed [6:0]  w_vel_inc;
  logic signed [5:0]  w_vel_fall, w_vel_move;
  logic signed [11:0] w_pos_sum, w_pos_clamp;
  logic               w_out_of_gap;

  assign w_edge = r_flap_s2 & ~r_flap_d;

  // Edge coinciding with a tick survives that tick and is seen by the next one.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_flap_s1   <= 1'b0;
      r_flap_s2   <= 1'b0;
      r_flap_d    <= 1'b0;
      r_flap_pend <= 1'b0;
    end else begin
      r_flap_s1 <= flap;
      r_flap_s2 <= r_flap_s1;
      r_flap_d  <= r_flap_s2;
      if (frame_tick)
        r_flap_pend <= w_edge;
      else if (w_edge)
        r_flap_pend <= 1'b1;
    end
  end

  always_comb begin
    w_vel_inc    = {r_vel[5], r_vel} + LP_GRAV;
    w_vel_fall   = (w_vel_inc > LP_MAXF) ? LP_MAXF[5:0] : w_vel_inc[5:0];
    w_vel_move   = (r_state == S_PLAY && r_flap_pend) ? LP_FLAP_VEL : w_vel_fall;
    w_pos_sum    = $signed({2'b00, r_bird_y}) + {{6{w_vel_move[5]}}, w_vel_move};
    if (w_pos_sum < LP_CEIL)
      w_pos_clamp = LP_CEIL;
    else if (w_pos_sum > LP_FLOOR)
      w_pos_clamp = LP_FLOOR;
    else
      w_pos_clamp = w_pos_sum;
    w_out_of_gap = (w_pos_clamp < LP_YMIN) || (w_pos_clamp > LP_YMAX);
  end

  always_comb begin
    w_state_n  = r_state;
    w_bird_y_n = r_bird_y;
    w_vel_n    = r_vel;
    w_score_n  = r_score;
    w_dcnt_n   = r_dcnt;
    case (r_state)
      S_IDLE: begin
        w_bird_y_n = LP_START;
        w_vel_n    = '0;
        if (frame_tick && (start || r_flap_pend)) begin
          w_state_n = S_PLAY;
          w_score_n = '0;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          w_vel_n    = w_vel_move;
          w_bird_y_n = w_pos_clamp[9:0];
          if (w_out_of_gap) begin
            w_state_n = S_DYING;
            w_dcnt_n  = '0;
          end else if (r_score != '1) begin
            w_score_n = r_score + 16'd1;
          end
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          w_vel_n    = w_vel_fall;
          w_bird_y_n = w_pos_clamp[9:0];
          w_dcnt_n   = r_dcnt + 6'd1;
          if (w_pos_clamp == LP_FLOOR || r_dcnt == LP_DLAST)
            w_state_n = S_OVER;
        end
      end
      S_OVER: begin
        if (frame_tick && start) begin
          w_state_n  = S_IDLE;
          w_bird_y_n = LP_START;
          w_vel_n    = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= S_IDLE;
      r_bird_y <= LP_START;
      r_vel    <= '0;
      r_score  <= '0;
      r_dcnt   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_bird_y <= w_bird_y_n;
      r_vel    <= w_vel_n;
      r_score  <= w_score_n;
      r_dcnt   <= w_dcnt_n;
    end
  end

`ifdef DEATH_FLASH_EN
  localparam int LP_FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [LP_FW-1:0] LP_FLAST = LP_FW'(FLASH_PERIOD - 1);

  logic [LP_FW-1:0] r_flash_cnt;
  logic             r_inv;

  // Flash phase restarts on DYING entry; OVER and IDLE always show the normal palette.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_flash_cnt <= '0;
      r_inv       <= 1'b0;
    end else if (frame_tick) begin
      if (r_state == S_DYING && w_state_n == S_DYING) begin
        if (r_flash_cnt == LP_FLAST) begin
          r_flash_cnt <= '0;
          r_inv       <= ~r_inv;
        end else begin
          r_flash_cnt <= r_flash_cnt + 1'b1;
        end
      end else begin
        r_flash_cnt <= '0;
        r_inv       <= 1'b0;
      end
    end
  end

  assign inverted = r_inv;
`else
  logic w_flash_unused;
  assign w_flash_unused = (FLASH_PERIOD == 0);
  assign inverted       = 1'b0;
`endif

  assign bird_y    = {22'd0, r_bird_y};
  assign playing   = (r_state == S_PLAY);
  assign game_over = (r_state == S_OVER);
  assign score     = r_score;

endmodule

// File: tb/tb_bird_game_controller.sv
// Directed self-checking bench for bird_game_controller (honours DEATH_FLASH_EN if defined).
module tb_bird_game_controller;

  logic        clock = 1'b0;
  logic        reset_L;
  logic        frame_tick;
  logic        flap;
  logic        start;
  logic [31:0] bird_y;
  logic        inverted;
  logic        playing;
  logic        game_over;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  bird_game_controller dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .frame_tick (frame_tick),
    .flap       (flap),
    .start      (start),
    .bird_y     (bird_y),
    .inverted   (inverted),
    .playing    (playing),
    .game_over  (game_over),
    .score      (score)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int y, input int sc,
                              input logic pl, input logic go, input logic inv);
    check({tag, ".bird_y"},    bird_y,          32'(y));
    check({tag, ".score"},     {16'd0, score},  32'(sc));
    check({tag, ".playing"},   {31'd0, playing},   {31'd0, pl});
    check({tag, ".game_over"}, {31'd0, game_over}, {31'd0, go});
    check({tag, ".inverted"},  {31'd0, inverted},  {31'd0, inv});
  endtask

  // One-cycle frame tick; returns on the following falling edge with outputs settled.
  task automatic tick();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
  endtask

  // Button press long enough to pass the synchronizer, released long enough to re-arm.
  task automatic do_flap();
    @(negedge clock) flap = 1'b1;
    repeat (4) @(negedge clock);
    flap = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock) reset_L = 1'b0;
    #1;
    check_status("reset_async", 240, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check_status("reset_rel", 240, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_y;
    logic exp_inv;
    reset_L    = 1'b0;
    frame_tick = 1'b0;
    flap       = 1'b0;
    start      = 1'b0;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check_status("por", 240, 0, 1'b0, 1'b0, 1'b0);

    // Idle tick without start stays idle
    tick();
    check_status("idle_hold", 240, 0, 1'b0, 1'b0, 1'b0);

    // Start: no movement on the start tick
    start = 1'b1; tick(); start = 1'b0;
    check_status("start", 240, 0, 1'b1, 1'b0, 1'b0);

    // Free fall 241, 243, 246 (vel ends at 3)
    tick(); check_status("fall1", 241, 1, 1'b1, 1'b0, 1'b0);
    tick(); check_status("fall2", 243, 2, 1'b1, 1'b0, 1'b0);
    tick(); check_status("fall3", 246, 3, 1'b1, 1'b0, 1'b0);

    // Flap between ticks: vel -8
    do_flap();
    tick(); check_status("flap", 238, 4, 1'b1, 1'b0, 1'b0);

    // Edge landing in the tick cycle: this tick falls (vel -7), next tick flaps
    @(negedge clock) flap = 1'b1;
    @(negedge clock);
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
    check_status("flap_in_tick", 231, 5, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    flap = 1'b0;
    repeat (3) @(negedge clock);
    tick(); check_status("flap_deferred", 223, 6, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of play
    do_reset();

    // Bottom collision from 240 with no flaps
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    check_status("gap_edge", 324, 14, 1'b1, 1'b0, 1'b0);
    tick();
    check_status("hit_bottom", 332, 14, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_y = 332 + 8 * k;
      if (exp_y > 474) exp_y = 474;
`ifdef DEATH_FLASH_EN
      exp_inv = (k >= 8 && k < 16);
`else
      exp_inv = 1'b0;
`endif
      check_status($sformatf("dying%0d", k), exp_y, 14, 1'b0, (k == 18), exp_inv);
    end

    // OVER ignores flaps and ticks without start
    tick(); check_status("over_hold", 474, 14, 1'b0, 1'b1, 1'b0);
    do_flap();
    tick(); check_status("over_flap", 474, 14, 1'b0, 1'b1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check_status("over_restart", 240, 14, 1'b0, 1'b0, 1'b0);

    // Flap alone starts the game from IDLE
    do_flap();
    tick(); check_status("flap_start", 240, 0, 1'b1, 1'b0, 1'b0);

    // Top collision: flap every tick
    for (int k = 1; k <= 10; k++) begin
      do_flap();
      tick();
      check_status($sformatf("climb%0d", k), 240 - 8 * k, k, 1'b1, 1'b0, 1'b0);
    end
    do_flap();
    tick(); check_status("hit_top", 152, 10, 1'b0, 1'b0, 1'b0);

    // Flaps ignored while dying: vel -8 -> -7
    do_flap();
    tick(); check_status("dying_noflap", 145, 10, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of DYING
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bird_game_controller.md
Name: bird_game_controller

Overview:
- Per-frame game sequencer for the flappy-bird display path.
- Owns bird vertical position and velocity, the flap input, pipe-gap collision and the game state machine.
- Drives the bird_y and inverted inputs of the pixel colour mapper, plus status outputs to the top level.
- Updates only on frame_tick, so bird_y is stable for a whole displayed frame.

Parameters:
- START_Y, 240, bird_y value loaded in IDLE.
- GRAVITY, 1, added to velocity each PLAY/DYING frame.
- FLAP_IMPULSE, 8, velocity is set to -FLAP_IMPULSE on a flap.
- MAX_FALL, 8, positive velocity saturation.
- Y_MIN, 157, smallest legal bird_y in PLAY (gap top row 151 plus 6).
- Y_MAX, 324, largest legal bird_y in PLAY (gap bottom row 329 minus 5).
- FLOOR_Y, 474, bird_y clamp ceiling; value at which DYING ends.
- DYING_FRAMES, 60, maximum frames spent in DYING.
- FLASH_PERIOD, 8, frames per inverted-toggle in DYING (optional feature).

Ports:
- clock, input, 1, system clock.
- reset_L, input, 1, asynchronous active-low reset.
- frame_tick, input, 1, one-cycle pulse at start of vertical blank.
- flap, input, 1, raw asynchronous button.
- start, input, 1, synchronous level, sampled only on frame_tick.
- bird_y, output, 32, bird centre row (upper 22 bits always 0).
- inverted, output, 1, palette invert select to colour mapper.
- playing, output, 1, high in PLAY.
- game_over, output, 1, high in OVER.
- score, output, 16, frames survived in PLAY.

Behaviour:
- One clock domain. reset_L is asynchronous and active-low.
- Reset values: state IDLE, bird_y = START_Y, vel = 0, score = 0, inverted = 0, playing = 0, game_over = 0, flap_pending = 0, dying counter = 0.
- Flap input path:
  - flap passes through a 2-FF synchronizer, then a rising-edge detector.
  - An edge sets flap_pending.
  - flap_pending is cleared on frame_tick.
  - An edge in the same cycle as frame_tick is not consumed by that tick; flap_pending is left set for the next tick.
- All state, position, velocity and score updates happen only in cycles with frame_tick = 1. Outputs are registered: effect is visible the cycle after the tick.
- Arithmetic:
  - vel is signed 6 bits; position math is signed 12 bits.
  - bird_y_next = clamp(bird_y + vel_next, 6, FLOOR_Y), then zero-extended to 32 bits.
- IDLE:
  - bird_y held at START_Y, vel = 0.
  - On a tick with start = 1 or flap_pending = 1: go to PLAY, score = 0, vel = 0, no position change that tick.
- PLAY, on each tick:
  - vel_next = flap_pending ? -FLAP_IMPULSE : min(vel + GRAVITY, MAX_FALL).
  - bird_y updated to bird_y_next.
  - If bird_y_next < Y_MIN or bird_y_next > Y_MAX: go to DYING, score unchanged, dying counter = 0.
  - Otherwise score += 1, saturating at 0xFFFF.
- DYING:
  - Flaps are ignored; flap_pending is still cleared on each tick.
  - Each tick: vel = min(vel + GRAVITY, MAX_FALL), bird_y updated, counter += 1.
  - When bird_y_next == FLOOR_Y, or counter reaches DYING_FRAMES - 1: go to OVER.
- OVER:
  - bird_y and score frozen; game_over = 1.
  - On a tick with start = 1: go to IDLE, bird_y = START_Y, vel = 0, inverted = 0.
- start and flap_pending are both honoured in IDLE. Only start is honoured in OVER.
- Reset asserted mid-frame or mid-DYING returns everything to reset values immediately.

Optional Feature:
- Macro DEATH_FLASH_EN.
- Defined: in DYING, inverted toggles on every FLASH_PERIOD-th tick, counted from DYING entry. Entering OVER forces inverted = 0.
- Undefined: inverted is constant 0. The flash counter logic is not compiled in.

Test Plan:
- Reset: hold reset_L = 0 mid-run, release -> bird_y = 240, state IDLE, score = 0, all flags 0.
- Start plus free fall: start on a tick, then 3 ticks with no flap -> bird_y = 241, 243, 246; playing = 1; score = 3.
- Flap: flap edge between ticks with vel = 3 -> next tick vel = -8, bird_y drops by 8. A flap edge in the tick cycle itself applies on the following tick.
- Gap collision, no flaps from 240: ticks 1-14 reach 324 with score = 14. Tick 15 -> bird_y = 332, DYING, score stays 14. The bird then falls to 474 (clamped) after 18 more ticks -> game_over = 1.
- Top collision: flap every tick from 240 -> bird_y = 232, 224, ..., 160, then 152 < 157 -> DYING.
- With DEATH_FLASH_EN: inverted toggles at DYING ticks 8 and 16, then is 0 in OVER. start in OVER -> IDLE, bird_y = 240.
